// File: rtl/rf_wb_pkg.sv
// Shared constants for the register-file writeback arbiter.
package rf_wb_pkg;

   // Default register address and data widths.
   localparam int unsigned RF_AW = 5;
   localparam int unsigned RF_DW = 32;

   // Fixed source slots on the writeback network.
   localparam int unsigned SRC_ALU = 0;
   localparam int unsigned SRC_MEM = 1;
   localparam int unsigned SRC_MUL = 2;

endpackage

// File: rtl/rr_pick.sv
// Rotating first-set search: returns the first requesting, non-excluded index at or after start,
// wrapping modulo N.
module rr_pick #(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic [N-1:0]  excl,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Walk the ring from the far end back towards start so the nearest candidate wins last.
   always_comb begin
      logic [IW-1:0] j;
      idx   = '0;
      found = 1'b0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         j = IW'((32'(start) + 32'(k)) % N);
         if (req[j] && !excl[j]) begin
            idx   = j;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: one holding entry per source, two RF write ports, round-robin
// scan starting at rr. Port 2 never writes the same register as port 1 in a cycle.
// Optional feature: define RF_WB_STALL_CNT_EN to add the 32-bit stall_cnt output.
module rf_wb_arbiter
   import rf_wb_pkg::*;
#(
   parameter int unsigned NSRC = 3,
   parameter int unsigned AW   = RF_AW,
   parameter int unsigned DW   = RF_DW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NSRC-1:0]      src_valid,
   input  logic [NSRC*AW-1:0]   src_addr,
   input  logic [NSRC*DW-1:0]   src_data,
   output logic [NSRC-1:0]      src_ready,
   input  logic                 flush,
   output logic                 we,
   output logic [AW-1:0]        waddr,
   output logic [DW-1:0]        wdata,
   output logic                 we2,
   output logic [AW-1:0]        waddr2,
   output logic [DW-1:0]        wdata2,
   output logic [2**AW-1:0]     busy
`ifdef RF_WB_STALL_CNT_EN
   ,
   output logic [31:0]          stall_cnt
`endif
);

   localparam int unsigned IW = $clog2(NSRC);

   logic [NSRC-1:0] hv_q, hv_d;
   logic [AW-1:0]   ha_q [NSRC];
   logic [DW-1:0]   hd_q [NSRC];
   logic [IW-1:0]   rr_q, rr_d;

   logic [IW-1:0]   idx1, idx2;
   logic            found1, found2;
   logic            gnt1, gnt2;
   logic [NSRC-1:0] same;
   logic [NSRC-1:0] gnt;
   logic [NSRC-1:0] accept;

   // Port 1: first held entry in scan order.
   rr_pick #(
      .N  (NSRC),
      .IW (IW)
   ) u_pick1 (
      .req   (hv_q),
      .start (rr_q),
      .excl  ('0),
      .idx   (idx1),
      .found (found1)
   );

   // Entries targeting the port-1 register (including port 1 itself) are kept off port 2.
   always_comb begin
      same = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         same[i] = (ha_q[i] == ha_q[idx1]);
      end
   end

   // Port 2: next held entry in scan order with a different register.
   rr_pick #(
      .N  (NSRC),
      .IW (IW)
   ) u_pick2 (
      .req   (hv_q),
      .start (rr_q),
      .excl  (same),
      .idx   (idx2),
      .found (found2)
   );

   // Grants, acceptances and next held state; flush kills both grants and loads.
   always_comb begin
      gnt1 = found1 && !flush;
      gnt2 = found1 && found2 && !flush;
      gnt  = '0;
      if (gnt1) gnt[idx1] = 1'b1;
      if (gnt2) gnt[idx2] = 1'b1;
      src_ready = ~hv_q | gnt;
      accept    = src_valid & src_ready & {NSRC{!flush}};
      if (flush) begin
         hv_d = '0;
      end else begin
         hv_d = accept | (hv_q & ~gnt);
      end
   end

   // Pointer moves just past the last entry granted in scan order; holds when idle.
   always_comb begin
      rr_d = rr_q;
      if (gnt2) begin
         rr_d = (idx2 == IW'(NSRC - 1)) ? '0 : idx2 + IW'(1);
      end else if (gnt1) begin
         rr_d = (idx1 == IW'(NSRC - 1)) ? '0 : idx1 + IW'(1);
      end
   end

   // Held entries and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hv_q <= '0;
         rr_q <= '0;
         for (int i = 0; i < int'(NSRC); i++) begin
            ha_q[i] <= '0;
            hd_q[i] <= '0;
         end
      end else begin
         hv_q <= hv_d;
         rr_q <= rr_d;
         for (int i = 0; i < int'(NSRC); i++) begin
            if (accept[i]) begin
               ha_q[i] <= src_addr[i*AW +: AW];
               hd_q[i] <= src_data[i*DW +: DW];
            end
         end
      end
   end

   // RF write ports straight from the granted entries; idle ports read as zero.
   always_comb begin
      we     = 1'b0;
      waddr  = '0;
      wdata  = '0;
      we2    = 1'b0;
      waddr2 = '0;
      wdata2 = '0;
      if (gnt1) begin
         we    = 1'b1;
         waddr = ha_q[idx1];
         wdata = hd_q[idx1];
      end
      if (gnt2) begin
         we2    = 1'b1;
         waddr2 = ha_q[idx2];
         wdata2 = hd_q[idx2];
      end
   end

   // Pending-write scoreboard derived only from held state.
   always_comb begin
      busy = '0;
      for (int i = 0; i < int'(NSRC); i++) begin
         if (hv_q[i]) busy[ha_q[i]] = 1'b1;
      end
   end

`ifdef RF_WB_STALL_CNT_EN
   logic [31:0] stall_q;

   // Counts cycles where at least one held entry waits; saturating, unaffected by flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (|(hv_q & ~gnt) && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter (default build, NSRC=3, AW=5, DW=32).
module tb_rf_wb_arbiter;
   import rf_wb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  src_valid;
   logic [14:0] src_addr;
   logic [95:0] src_data;
   logic [2:0]  src_ready;
   logic        flush;
   logic        we, we2;
   logic [4:0]  waddr, waddr2;
   logic [31:0] wdata, wdata2;
   logic [31:0] busy;

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .src_valid (src_valid),
      .src_addr  (src_addr),
      .src_data  (src_data),
      .src_ready (src_ready),
      .flush     (flush),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .we2       (we2),
      .waddr2    (waddr2),
      .wdata2    (wdata2),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: held requests as plain arrays plus a scan pointer.
   bit          m_hv [3];
   logic [4:0]  m_ha [3];
   logic [31:0] m_hd [3];
   int          m_rr;
   int          p1, p2;
   bit          g1, g2;
   logic        e_we, e_we2;
   logic [4:0]  e_waddr, e_waddr2;
   logic [31:0] e_wdata, e_wdata2, e_busy;
   logic [2:0]  e_ready;

   // Last observed outputs and the register file they imply.
   logic        o_we, o_we2;
   logic [4:0]  o_waddr, o_waddr2;
   logic [31:0] o_busy;
   logic [31:0] rf_obs [32];
   int          gcount [3];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_hv[i] = 1'b0;
      m_rr = 0;
   endtask

   task automatic model_eval();
      int j;
      p1 = -1;
      p2 = -1;
      for (int k = 0; k < 3; k++) begin
         j = (m_rr + k) % 3;
         if (m_hv[j] && p1 < 0) p1 = j;
      end
      if (p1 >= 0) begin
         for (int k = 0; k < 3; k++) begin
            j = (m_rr + k) % 3;
            if (m_hv[j] && j != p1 && m_ha[j] != m_ha[p1] && p2 < 0) p2 = j;
         end
      end
      g1 = (p1 >= 0) && !flush;
      g2 = (p2 >= 0) && !flush;
      e_we = g1;  e_waddr = '0;  e_wdata = '0;
      e_we2 = g2; e_waddr2 = '0; e_wdata2 = '0;
      if (g1) begin e_waddr = m_ha[p1]; e_wdata = m_hd[p1]; end
      if (g2) begin e_waddr2 = m_ha[p2]; e_wdata2 = m_hd[p2]; end
      e_busy = '0;
      for (int i = 0; i < 3; i++) begin
         e_ready[i] = !m_hv[i] || (g1 && p1 == i) || (g2 && p2 == i);
         if (m_hv[i]) e_busy[m_ha[i]] = 1'b1;
      end
   endtask

   task automatic model_update();
      bit gi;
      for (int i = 0; i < 3; i++) begin
         gi = (g1 && p1 == i) || (g2 && p2 == i);
         if (flush) begin
            m_hv[i] = 1'b0;
         end else if (src_valid[i] && e_ready[i]) begin
            m_hv[i] = 1'b1;
            m_ha[i] = src_addr[i*5 +: 5];
            m_hd[i] = src_data[i*32 +: 32];
         end else if (gi) begin
            m_hv[i] = 1'b0;
         end
      end
      if (g2) m_rr = (p2 + 1) % 3;
      else if (g1) m_rr = (p1 + 1) % 3;
   endtask

   // One clock: compare outputs at the falling edge, then advance the model past the rising edge.
   task automatic cycle();
      @(negedge clk);
      model_eval();
      chk("src_ready", 64'(src_ready), 64'(e_ready));
      chk("we", 64'(we), 64'(e_we));
      chk("waddr", 64'(waddr), 64'(e_waddr));
      chk("wdata", 64'(wdata), 64'(e_wdata));
      chk("we2", 64'(we2), 64'(e_we2));
      chk("waddr2", 64'(waddr2), 64'(e_waddr2));
      chk("wdata2", 64'(wdata2), 64'(e_wdata2));
      chk("busy", 64'(busy), 64'(e_busy));
      o_we = we; o_we2 = we2; o_waddr = waddr; o_waddr2 = waddr2; o_busy = busy;
      if (we) rf_obs[waddr] = wdata;
      if (we2) rf_obs[waddr2] = wdata2;
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic set_src(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
      src_valid[i]       = v;
      src_addr[i*5 +: 5]  = a;
      src_data[i*32 +: 32] = d;
   endtask

   task automatic idle();
      src_valid = '0;
      flush     = 1'b0;
   endtask

   initial begin
      int mx, mn;
      rst = 1'b1;
      src_valid = '0;
      src_addr  = '0;
      src_data  = '0;
      flush     = 1'b0;
      model_reset();
      #3;
      chk("rst_ready", 64'(src_ready), 64'h7);
      chk("rst_we", 64'({we, we2}), 64'h0);
      chk("rst_addr", 64'({waddr, waddr2}), 64'h0);
      chk("rst_data", {wdata, wdata2}, 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Idle after reset.
      cycle();

      // Two sources, distinct registers: both ports in the following cycle.
      set_src(SRC_ALU, 1'b1, 5'd3, 32'hFFFF_FFFF);
      set_src(SRC_MEM, 1'b1, 5'd4, 32'd2);
      cycle();
      idle();
      cycle();
      chk("dual_we", 64'({o_we, o_we2}), 64'h3);
      chk("dual_waddr", 64'(o_waddr), 64'd3);
      chk("dual_waddr2", 64'(o_waddr2), 64'd4);
      chk("rf_r3", 64'(rf_obs[3]), 64'hFFFF_FFFF);
      chk("rf_r4", 64'(rf_obs[4]), 64'd2);

      // Three sources on one register: serialised one per cycle, busy held until the last.
      set_src(SRC_ALU, 1'b1, 5'd5, 32'd177);
      set_src(SRC_MEM, 1'b1, 5'd5, 32'd178);
      set_src(SRC_MUL, 1'b1, 5'd5, 32'd179);
      cycle();
      idle();
      for (int n = 0; n < 3; n++) begin
         cycle();
         chk("same_we", 64'({o_we, o_we2}), 64'h2);
         chk("same_busy5", 64'(o_busy[5]), 64'h1);
      end
      cycle();
      chk("same_done", 64'({o_we, o_busy[5]}), 64'h0);

      // Continuous traffic on distinct registers: fairness over 30 cycles.
      for (int i = 0; i < 3; i++) gcount[i] = 0;
      set_src(SRC_ALU, 1'b1, 5'd10, 32'hA0);
      set_src(SRC_MEM, 1'b1, 5'd11, 32'hB0);
      set_src(SRC_MUL, 1'b1, 5'd12, 32'hC0);
      for (int n = 0; n < 30; n++) begin
         cycle();
         if (o_we) gcount[o_waddr - 5'd10]++;
         if (o_we2) gcount[o_waddr2 - 5'd10]++;
      end
      mx = gcount[0]; mn = gcount[0];
      for (int i = 1; i < 3; i++) begin
         if (gcount[i] > mx) mx = gcount[i];
         if (gcount[i] < mn) mn = gcount[i];
      end
      chk("fair_spread", 64'(mx - mn <= 1), 64'h1);
      chk("fair_total", 64'(gcount[0] + gcount[1] + gcount[2]), 64'd58);
      idle();
      repeat (3) cycle();

      // Flush before the grant drops the held request.
      set_src(SRC_MUL, 1'b1, 5'd7, 32'h77);
      cycle();
      idle();
      flush = 1'b1;
      cycle();
      chk("flush_we", 64'({o_we, o_we2}), 64'h0);
      flush = 1'b0;
      cycle();
      chk("flush_busy7", 64'(o_busy[7]), 64'h0);
      chk("flush_we_after", 64'(o_we), 64'h0);

      // Asynchronous reset with two entries held.
      set_src(SRC_ALU, 1'b1, 5'd9, 32'h99);
      set_src(SRC_MEM, 1'b1, 5'd10, 32'h1010);
      cycle();
      idle();
      #2;
      rst = 1'b1;
      #1;
      chk("arst_we", 64'({we, we2}), 64'h0);
      chk("arst_addr", 64'({waddr, waddr2}), 64'h0);
      chk("arst_busy", 64'(busy), 64'h0);
      chk("arst_ready", 64'(src_ready), 64'h7);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      model_reset();
      cycle();
      set_src(SRC_ALU, 1'b1, 5'd20, 32'h20);
      set_src(SRC_MEM, 1'b1, 5'd21, 32'h21);
      set_src(SRC_MUL, 1'b1, 5'd22, 32'h22);
      cycle();
      idle();
      cycle();
      chk("arst_rr0", 64'(o_waddr), 64'd20);
      repeat (2) cycle();

      // Random traffic with frequent register collisions, register 0 included.
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 3; i++) begin
            set_src(i, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         end
         flush = ($urandom_range(0, 15) == 0);
         cycle();
      end
      idle();
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
